// File: rtl/i2c_gain_slave.sv
// i2c_gain_slave: I2C slave holding a bank of 8-bit gain registers (one per band).
// Write: START, {addr,0}, register pointer, data bytes. Read: START, {addr,1}, data.
// The pointer auto-increments and wraps after every committed write or acked read.
// Ports:
//   clk         system clock; everything runs on its rising edge
//   rst_n       asynchronous active-low reset
//   scl         I2C clock from the master (asynchronous to clk)
//   sda         I2C data; driven only to 0 or released (z)
//   gains       flattened gain bank; register k is gains[8k+7:8k]
//   gain_update one-cycle pulse on the cycle after a register write commits
//   busy        high from an accepted address match until STOP or repeated START
module i2c_gain_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h6A,
  parameter int         NUM_REGS   = 10,
  parameter logic [7:0] RESET_GAIN = 8'd16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [NUM_REGS*8-1:0] gains,
  output logic                  gain_update,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  localparam logic [7:0] NREG8 = 8'(NUM_REGS);
  localparam logic [7:0] LAST8 = 8'(NUM_REGS - 1);

  state_t                     state, state_n;
  logic                       scl_m, scl_s, scl_d, sda_m, sda_s, sda_d;
  logic [3:0]                 cnt;
  logic [7:0]                 sreg, ptr, ptr_inc, rd_cur, rd_next;
  logic                       oe, mack;
  logic [NUM_REGS-1:0][7:0]   regs;
  logic                       scl_rise, scl_fall, start_c, stop_c, bus_evt;
  logic                       byte_done, in_range, addr_hit, rw, wr_commit;

  // Out-of-range pointers read back as zero.
  function automatic logic [7:0] reg_at(input logic [NUM_REGS-1:0][7:0] r, input logic [7:0] p);
    reg_at = 8'h00;
    for (int k = 0; k < NUM_REGS; k++)
      if (p == 8'(k)) reg_at = r[k];
  endfunction

  // Two synchronizer flops, then a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {scl_m, scl_s, scl_d} <= 3'b111;
      {sda_m, sda_s, sda_d} <= 3'b111;
    end else begin
      scl_m <= scl;  scl_s <= scl_m;  scl_d <= scl_s;
      sda_m <= sda;  sda_s <= sda_m;  sda_d <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_c   = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c    = scl_s & scl_d & ~sda_d & sda_s;
  assign bus_evt   = start_c | stop_c;
  assign byte_done = (cnt == 4'd8);
  assign in_range  = (ptr < NREG8);
  assign addr_hit  = (sreg[7:1] == SLAVE_ADDR);
  assign rw        = sreg[0];
  assign rd_cur    = reg_at(regs, ptr);
  assign rd_next   = reg_at(regs, ptr_inc);
  assign wr_commit = !bus_evt && (state == WR_DATA) && scl_fall && byte_done && in_range;

  always_comb begin
    if (ptr == LAST8)     ptr_inc = 8'd0;
    else if (ptr < NREG8) ptr_inc = ptr + 8'd1;
    else                  ptr_inc = ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Byte boundaries and ACK slots both end on the synchronized scl fall.
  always_comb begin
    state_n = state;
    if (start_c)     state_n = DEV_ADDR;
    else if (stop_c) state_n = IDLE;
    else begin
      case (state)
        DEV_ADDR: if (scl_fall && byte_done) state_n = addr_hit ? DEV_ACK : IDLE;
        DEV_ACK:  if (scl_fall) state_n = rw ? RD_DATA : REG_ADDR;
        REG_ADDR: if (scl_fall && byte_done) state_n = REG_ACK;
        REG_ACK:  if (scl_fall) state_n = WR_DATA;
        WR_DATA:  if (scl_fall && byte_done) state_n = WR_ACK;
        WR_ACK:   if (scl_fall) state_n = WR_DATA;
        RD_DATA:  if (scl_fall && byte_done) state_n = RD_ACK;
        RD_ACK:   if (scl_fall) state_n = mack ? RD_DATA : IDLE;
        default:  state_n = state;
      endcase
    end
  end

  always_comb begin
    busy = !((state == IDLE) || (state == DEV_ADDR));
  end

  assign sda   = oe ? 1'b0 : 1'bz;
  assign gains = regs;

  // Datapath: bit counter, shift register, pointer, sda drive and the gain bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sreg        <= '0;
      ptr         <= '0;
      oe          <= 1'b0;
      mack        <= 1'b0;
      gain_update <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_GAIN;
    end else begin
      gain_update <= wr_commit;
      if (bus_evt) begin
        // Any partial byte is dropped here; only wr_commit touches regs.
        cnt <= '0;
        oe  <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR, REG_ADDR, WR_DATA: begin
            if (scl_rise && !byte_done) begin
              sreg <= {sreg[6:0], sda_s};
              cnt  <= cnt + 4'd1;
            end else if (scl_fall && byte_done) begin
              cnt <= '0;
              if (state == DEV_ADDR) oe <= addr_hit;
              else if (state == REG_ADDR) begin
                oe  <= 1'b1;
                ptr <= sreg;
              end else begin
                oe <= in_range;
                if (in_range) ptr <= ptr_inc;
              end
            end
          end
          DEV_ACK: if (scl_fall) begin
            // Read: first data bit goes out on the same fall that ends the ACK.
            if (rw) begin
              sreg <= rd_cur;
              oe   <= ~rd_cur[7];
            end else oe <= 1'b0;
          end
          REG_ACK, WR_ACK: if (scl_fall) oe <= 1'b0;
          RD_DATA: begin
            if (scl_rise && !byte_done) cnt <= cnt + 4'd1;
            else if (scl_fall) begin
              if (byte_done) begin
                cnt <= '0;
                oe  <= 1'b0;
              end else begin
                sreg <= {sreg[6:0], 1'b0};
                oe   <= ~sreg[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) mack <= ~sda_s;
            else if (scl_fall) begin
              if (mack) begin
                ptr  <= ptr_inc;
                sreg <= rd_next;
                oe   <= ~rd_next[7];
              end else oe <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      for (int k = 0; k < NUM_REGS; k++)
        if (wr_commit && ptr == 8'(k)) regs[k] <= sreg;
    end
  end

endmodule
